// File: rtl/mic1_uart_pkg.sv
// Shared definitions for the MIC-1 UART receive (and later transmit) paths.
package mic1_uart_pkg;

  // Data bits per character (8N1 framing).
  localparam int UART_BITS = 8;

  // Receiver deframing states.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Clocks per oversample tick, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    return (clk_hz + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage

// File: rtl/mic1_sync_fifo.sv
// Small synchronous FIFO: push with full flag, valid/ready pop.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module mic1_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("mic1_sync_fifo: DEPTH must be a power of 2 and >= 2");
  end

  // The extra MSB on each pointer separates full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop;
  logic             push_ok;

  assign out_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && (!full || pop);

  // Pointer update on accepted push and pop.
  // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would race other clocked blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; emptiness comes from the pointers, and out_data is gated to 0 while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Head-of-FIFO read, forced to 0 when nothing is held.
  // NOTE: default assignment first so every path drives out_data and no latch is inferred.
  always_comb begin
    out_data = '0;
    if (out_valid) out_data = mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/mic1_uart_rx.sv
// UART receiver for the MIC-1 iCEBreaker top: synchronise, oversample,
// deframe 8N1, buffer in a FIFO, flag framing and overrun events.
module mic1_uart_rx
  import mic1_uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ser_rx,
  output logic [UART_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int T_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(UART_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = 1;
  localparam logic [T_W-1:0]   T_LAST   = T_W'(OVERSAMPLE - 1);
  localparam logic [T_W-1:0]   T_ONE    = 1;
  localparam logic [T_W-1:0]   T_VOTE_A = T_W'(OVERSAMPLE / 2 - 1);
  localparam logic [T_W-1:0]   T_VOTE_B = T_W'(OVERSAMPLE / 2);
  localparam logic [T_W-1:0]   T_VOTE_C = T_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = 1;

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("mic1_uart_rx: OVERSAMPLE must be even and >= 4");
  end

  rx_state_t            state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic [T_W-1:0]       t_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [1:0]           samp_q;
  logic                 bit_val;
  logic [UART_BITS-1:0] shift_q;
  logic                 wait_high;

  logic tick;
  logic sub_start;
  logic samp_a;
  logic samp_b;
  logic samp_c;
  logic bit_end;
  logic vote;
  logic fifo_full;
  logic fifo_room;
  logic stop_decide;
  logic fifo_push;

  // Samples are taken at the start of sub-intervals A/B/C, so the three
  // votes straddle the bit centre; the last bit period ends on the final tick.
  assign tick      = (div_cnt == DIV_LAST);
  assign sub_start = (div_cnt == '0);
  assign samp_a    = sub_start && (t_cnt == T_VOTE_A);
  assign samp_b    = sub_start && (t_cnt == T_VOTE_B);
  assign samp_c    = sub_start && (t_cnt == T_VOTE_C);
  assign bit_end   = tick && (t_cnt == T_LAST);
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  // A same-cycle pop frees a slot, so fullness is judged after the pop.
  assign fifo_room   = !fifo_full || (rx_valid && rx_ready);
  assign stop_decide = (state == STOP) && samp_c;
  assign fifo_push   = stop_decide && vote && fifo_room;

  // Two-flop synchroniser for the asynchronous line, idling high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= ser_rx;
      rx_s    <= rx_meta;
    end
  end

  // Deframing FSM with its tick divider, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      t_cnt       <= '0;
      bit_idx     <= '0;
      samp_q      <= '0;
      bit_val     <= 1'b0;
      shift_q     <= '0;
      wait_high   <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;

      if (state == IDLE) begin
        div_cnt <= '0;
        t_cnt   <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        t_cnt   <= (t_cnt == T_LAST) ? '0 : t_cnt + T_ONE;
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end

      if (samp_a) samp_q[0] <= rx_s;
      if (samp_b) samp_q[1] <= rx_s;
      if (samp_c) bit_val   <= vote;

      case (state)
        IDLE: begin
          if (wait_high) begin
            if (rx_s) wait_high <= 1'b0;
          end else if (!rx_s) begin
            state   <= START;
            bit_idx <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            if (bit_val) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end
        DATA: begin
          if (samp_c) shift_q <= {vote, shift_q[UART_BITS-1:1]};
          if (bit_end) begin
            if (bit_idx == BIT_LAST) state <= STOP;
            else                     bit_idx <= bit_idx + BIT_ONE;
          end
        end
        STOP: begin
          if (samp_c) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
            if (!vote) begin
              frame_err <= 1'b1;
              wait_high <= 1'b1;
            end else if (!fifo_room) begin
              overrun_err <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  mic1_sync_fifo #(
    .WIDTH (UART_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (shift_q),
    .full      (fifo_full),
    .out_valid (rx_valid),
    .out_ready (rx_ready),
    .out_data  (rx_data)
  );

endmodule

// File: doc/mic1_uart_rx.md
Name: mic1_uart_rx

Overview:
Serial receive front end for the MIC-1 iCEBreaker top level. It takes the raw `ser_rx` pin and synchronises it. It oversamples the line, deframes 8N1 bytes and buffers them in a small FIFO. Bytes are presented to the MIC-1 I/O stage over a valid/ready interface, and framing and overrun events are flagged for LED/status use.

Parameters:
- CLK_HZ, 12000000, system clock frequency (iCEBreaker oscillator).
- BAUD, 115200, line rate.
- OVERSAMPLE, 8, sample ticks per bit; must be even and >= 4.
- FIFO_DEPTH, 4, received-byte buffer entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ser_rx  in  1  raw UART line, idle high, asynchronous to clk
- rx_data  out  8  head-of-FIFO byte; valid only while rx_valid=1
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun_err  out  1  one-cycle pulse: complete byte dropped because FIFO full
- rx_busy  out  1  high while the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, active-high) forces:
  - synchroniser flops to 1;
  - FSM to IDLE;
  - tick divider, bit and tick counters to 0;
  - FIFO empty;
  - rx_valid=0, rx_data=0, frame_err=0, overrun_err=0, rx_busy=0.
- Reset asserted mid-frame abandons the frame; no partial byte is ever written.
- Input path: 2-flop synchroniser; all logic uses the second flop (rx_s).
- Tick generator:
  - DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), i.e. rounded to nearest. Default is 13, giving one bit = 104 clk.
  - Divider counts 0..DIV-1 and emits a one-clk tick at DIV-1.
  - Divider is held at 0 in IDLE and restarts on the start edge.
- Majority vote: within each bit, tick counter t counts 0..OVERSAMPLE-1. The bit value is the majority of rx_s at t = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- FSM states:
  - IDLE: on rx_s=0 -> START, clear counters.
  - START: at end of bit period, if voted value=1 (glitch) -> IDLE with no flags; else -> DATA, bit index 0.
  - DATA: LSB first; voted bit shifted into the shift register. After bit 7's period -> STOP.
  - STOP: at the centre vote tick (t=OVERSAMPLE/2+1) decide and go to IDLE immediately. Leaving at the centre allows a back-to-back start bit to be detected.
- STOP decision:
  - Voted 1 and FIFO not full: byte written to FIFO.
  - Voted 1 and FIFO full: byte discarded, overrun_err pulses.
  - Voted 0: byte discarded, frame_err pulses. FSM returns to IDLE and waits for rx_s=1 before a new start is accepted; a break does not retrigger.
- FIFO:
  - Write at the STOP decision cycle. rx_valid rises the cycle after the write (registered).
  - Pop when rx_valid & rx_ready.
  - Simultaneous write and pop on a full FIFO is a legal write, not an overrun: fullness is evaluated after the pop.
  - Pop on empty is ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide so full and empty are distinguishable.
- rx_data is combinational from the FIFO head register array. It holds stable while rx_valid=1 and no pop occurs.
- Latency: the write occurs at the centre of the stop bit, about 9.5 bit periods after the start-bit falling edge, plus 2 clk of synchroniser delay.

Decomposition:
- Shared package mic1_uart_pkg holds:
  - rx state enum (IDLE, START, DATA, STOP);
  - the DIV computation as a function;
  - UART_BITS=8 constant.
- One sub-module, mic1_sync_fifo (parameterised WIDTH/DEPTH, valid/ready pop, push with full flag). It is reused later by the TX path.

Test Plan:
- Send 0x55 at 115200 with rx_ready=1 -> rx_valid pulses 1 clk with rx_data=0x55. frame_err=0, overrun_err=0.
- 2 clk-wide low glitch on idle line -> FSM returns to IDLE after one bit period; no rx_valid, no flags.
- Send 0xA3 with the stop bit held low -> frame_err pulses once; FIFO stays empty. A following 0x3C sent after the line returns high -> rx_data=0x3C.
- rx_ready=0, send 0x01..0x05 back-to-back -> FIFO holds 0x01..0x04 and overrun_err pulses once (for 0x05). Draining yields 0x01,0x02,0x03,0x04 in order.
- FIFO full and rx_ready asserted on the same cycle as the 5th byte's STOP decision -> no overrun; drain yields 0x02..0x05.
- Assert rst at mid-frame (during DATA bit 3 of 0xFF) -> all outputs 0 immediately. Next full byte 0x7E is received correctly.
